adc_bitstream_capture: RTL

- Upstream front end of the ADC logging path. Captures four 1-bit ADC modulator bitstreams and their bit clock in the wb_clk_i domain.
- Deserialises each channel into 32-bit words, LSB-first. The first bit received lands in bit 0.
- Buffers complete 4-channel frames in a small FIFO and presents them one word at a time on a valid/ready stream. The blockram writer consumes this stream, so the writer no longer has to span clock domains.

---
 rtl/adc_bitstream_capture_if.sv | 22 ++
 rtl/adc_bitstream_capture.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/adc_bitstream_capture_if.sv
// Word stream from the ADC capture front end to the blockram writer.
// Valid/ready handshake carrying one 32-bit channel word per transfer.
interface adc_bitstream_capture_if;
  logic [31:0] word_dat_o;
  logic [1:0]  word_ch_o;
  logic        word_valid_o;
  logic        word_ready_i;

  modport master (
    output word_dat_o,
    output word_ch_o,
    output word_valid_o,
    input  word_ready_i
  );

  modport slave (
    input  word_dat_o,
    input  word_ch_o,
    input  word_valid_o,
    output word_ready_i
  );
endinterface

// File: rtl/adc_bitstream_capture.sv
// Captures four ADC bitstreams plus bit clock, deserialises 32-bit words
// LSB-first and streams buffered 4-channel frames one word at a time.
module adc_bitstream_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 2
) (
  input  logic               wb_clk_i,
  input  logic               reset,
  input  logic               enable,
  input  logic               adc_clk,
  input  logic               adc_a,
  input  logic               adc_b,
  input  logic               adc_c,
  input  logic               adc_d,
  adc_bitstream_capture_if.master word_if,
  input  logic               overflow_clr_i,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt_o,
  output logic [FIFO_AW:0]   fifo_level_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  // bit 4 = adc_clk, bits 3..0 = channels a..d, all through one chain
  logic [4:0]         r_sync [SYNC_STAGES];
  logic               r_clk_d;
  logic [31:0]        r_sh_a, r_sh_b, r_sh_c, r_sh_d;
  logic [4:0]         r_bit_cnt;
  logic [127:0]       r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr, r_rd;
  logic [FIFO_AW:0]   r_level;
  logic [1:0]         r_ch;
  logic               r_valid;
  logic               r_ovf;
  logic [7:0]         r_drop;

  logic [4:0]         w_s;
  logic               w_edge, w_done, w_full;
  logic               w_xfer, w_pop, w_push, w_drop;
  logic [31:0]        w_sh_a, w_sh_b, w_sh_c, w_sh_d;
  logic [FIFO_AW:0]   w_level_nxt;
  logic [127:0]       w_head;
  logic [31:0]        w_word;

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_clk_d <= 1'b0;
    end else begin
      r_sync[0] <= {adc_clk, adc_a, adc_b, adc_c, adc_d};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_clk_d <= w_s[4];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s[4] & ~r_clk_d;

  assign w_sh_a = {w_s[3], r_sh_a[31:1]};
  assign w_sh_b = {w_s[2], r_sh_b[31:1]};
  assign w_sh_c = {w_s[1], r_sh_c[31:1]};
  assign w_sh_d = {w_s[0], r_sh_d[31:1]};

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_sh_a    <= '0;
      r_sh_b    <= '0;
      r_sh_c    <= '0;
      r_sh_d    <= '0;
      r_bit_cnt <= '0;
    end else if (!enable) begin
      r_sh_a    <= '0;
      r_sh_b    <= '0;
      r_sh_c    <= '0;
      r_sh_d    <= '0;
      r_bit_cnt <= '0;
    end else if (w_edge) begin
      r_sh_a    <= w_sh_a;
      r_sh_b    <= w_sh_b;
      r_sh_c    <= w_sh_c;
      r_sh_d    <= w_sh_d;
      r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  // a full FIFO still takes a frame when its last word leaves this cycle
  assign w_done = w_edge & enable & (r_bit_cnt == 5'd31);
  assign w_full = (r_level == (FIFO_AW+1)'(DEPTH));
  assign w_xfer = r_valid & word_if.word_ready_i;
  assign w_pop  = w_xfer & (r_ch == 2'd3);
  assign w_push = w_done & (~w_full | w_pop);
  assign w_drop = w_done & ~w_push;

  assign w_level_nxt = r_level + (FIFO_AW+1)'(w_push)
                               - (FIFO_AW+1)'(w_pop);

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr] <= {w_sh_a, w_sh_b, w_sh_c, w_sh_d};
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_wr    <= r_wr + FIFO_AW'(w_push);
      r_rd    <= r_rd + FIFO_AW'(w_pop);
      r_level <= w_level_nxt;
      if (w_xfer) r_ch <= r_ch + 2'd1;
      // rises one cycle after the level does, drops with the last pop
      r_valid <= (r_level != '0) && (w_level_nxt != '0);
    end
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      else if (overflow_clr_i) r_ovf <= 1'b0;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign w_head = r_mem[r_rd];

  always_comb begin
    w_word = '0;
    unique case (r_ch)
      2'd0: w_word = w_head[127:96];
      2'd1: w_word = w_head[95:64];
      2'd2: w_word = w_head[63:32];
      2'd3: w_word = w_head[31:0];
    endcase
  end

  assign word_if.word_dat_o   = r_valid ? w_word : 32'd0;
  assign word_if.word_ch_o    = r_ch;
  assign word_if.word_valid_o = r_valid;
  assign overflow_o           = r_ovf;
  assign drop_cnt_o           = r_drop;
  assign fifo_level_o         = r_level;

endmodule
